// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable word width, stop bits and depth.
// Define UART_TX_PARITY_EN to add a parity bit per frame (even, or odd with PARITY_ODD=1).
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        txEn,
  input  logic                        wrEn,
  input  logic [DATA_BITS-1:0]        wrData,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        ovf,
  output logic                        txBusy,
  output logic                        txDone,
  output logic                        txOut
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int ADDR_W       = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W      = ADDR_W + 1;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_config
      $error("uart_tx_fifo: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 ovf_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Transmitter
  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q, done_q;
  logic                 baud_last, frame_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  assign full   = (level_q == LEVEL_W'(FIFO_DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign ovf    = ovf_q;
  assign txBusy = (state_q != ST_IDLE);
  assign txDone = done_q;
  assign txOut  = tx_q;
  assign head   = mem_q[rd_ptr_q];

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign frame_end = (state_q == ST_STOP) && baud_last && (bit_q == BIT_W'(STOP_BITS - 1));
  // A pop into an empty FIFO is impossible because it looks at the registered level only.
  assign pop  = txEn && !empty && ((state_q == ST_IDLE) || frame_end);
  assign push = wrEn && (!full || pop);

  always_comb begin
    // NOTE: default first so every path assigns level_d and no latch is inferred.
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      if (wrEn && !push) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wrData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      done_q <= 1'b0;
      if (state_q == ST_IDLE) baud_q <= '0;
      else                    baud_q <= baud_last ? '0 : baud_q + BAUD_W'(1);

      // txOut is the line value of the state being left, hence one clock behind the FSM.
      case (state_q)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            bit_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx_q <= parity_q;
          if (baud_last) state_q <= ST_STOP;
        end
`endif
        ST_STOP: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            if (bit_q == BIT_W'(STOP_BITS - 1)) begin
              done_q  <= 1'b1;
              bit_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A pop overrides the IDLE return above, giving back-to-back frames.
      if (pop) begin
        shift_q  <= head;
`ifdef UART_TX_PARITY_EN
        parity_q <= (^head) ^ PARITY_ODD[0];
`endif
        state_q  <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: hand-written frame vectors, directed corner sequences and a
// randomized run checked cycle by cycle against a queue/countdown model of DUT A.
module tb_uart_tx_fifo;

  localparam int CPB   = 12;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FRAME_CLKS = (1 + DB + PBIT + 1) * CPB;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  logic       txEn_a = 1'b0, wrEn_a = 1'b0;
  logic [7:0] wrData_a = '0;
  logic       full_a, empty_a, ovf_a, busy_a, done_a, txOut_a;
  logic [4:0] level_a;

  logic       txEn_b = 1'b0, wrEn_b = 1'b0;
  logic [8:0] wrData_b = '0;
  logic       full_b, empty_b, ovf_b, busy_b, done_b, txOut_b;
  logic [2:0] level_b;

  uart_tx_fifo #(.CLOCK_RATE(12000000), .BAUD_RATE(1000000), .DATA_BITS(8),
                 .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rstN(rstN), .txEn(txEn_a), .wrEn(wrEn_a), .wrData(wrData_a),
    .full(full_a), .empty(empty_a), .level(level_a), .ovf(ovf_a),
    .txBusy(busy_a), .txDone(done_a), .txOut(txOut_a));

  uart_tx_fifo #(.CLOCK_RATE(12000000), .BAUD_RATE(1000000), .DATA_BITS(9),
                 .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rstN(rstN), .txEn(txEn_b), .wrEn(wrEn_b), .wrData(wrData_b),
    .full(full_b), .empty(empty_b), .level(level_b), .ovf(ovf_b),
    .txBusy(busy_b), .txDone(done_b), .txOut(txOut_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model of DUT A ----------------
  int         q_m[$];
  int         rem_m  = 0;   // clocks left in the frame being sent, 0 when idle
  logic [15:0] cur_m = '1;
  bit         ovf_m  = 1'b0;
  logic       exp_out = 1'b1, exp_done = 1'b0;
  int err_out = 0, err_done = 0, err_level = 0, err_flags = 0;
  int base_out = 0, base_done = 0, base_level = 0, base_flags = 0;

  function automatic logic [15:0] frame_bits(input int w);
    logic [15:0] b;
    logic        p;
    b    = '1;
    b[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < DB; i++) begin
      b[1 + i] = w[i];
      p        = p ^ w[i];
    end
`ifdef UART_TX_PARITY_EN
    b[1 + DB] = p;
`endif
    return b;
  endfunction

  initial begin : model
    bit can_pop;
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        q_m.delete();
        rem_m    = 0;
        ovf_m    = 1'b0;
        exp_out  = 1'b1;
        exp_done = 1'b0;
      end else begin
        can_pop  = txEn_a && (q_m.size() != 0) && (rem_m <= 1);
        exp_out  = (rem_m == 0) ? 1'b1 : cur_m[(FRAME_CLKS - rem_m) / CPB];
        exp_done = (rem_m == 1);
        if (can_pop) begin
          cur_m = frame_bits(q_m.pop_front());
          rem_m = FRAME_CLKS;
        end else if (rem_m > 0) begin
          rem_m--;
        end
        if (wrEn_a) begin
          if (q_m.size() < DEPTH) q_m.push_back(int'(wrData_a));
          else                    ovf_m = 1'b1;
        end
      end
    end
  end

  initial begin : scoreboard
    forever begin
      @(negedge clk);
      if (txOut_a !== exp_out)            err_out++;
      if (done_a !== exp_done)            err_done++;
      if (int'(level_a) != q_m.size())    err_level++;
      if ({ovf_a, full_a, empty_a, busy_a} !==
          {ovf_m, q_m.size() == DEPTH, q_m.size() == 0, rem_m > 0}) err_flags++;
    end
  end

  task automatic model_check(input string ph);
    check({ph, "_model_txOut_errs"}, err_out - base_out, 0);
    check({ph, "_model_txDone_errs"}, err_done - base_done, 0);
    check({ph, "_model_level_errs"}, err_level - base_level, 0);
    check({ph, "_model_flag_errs"}, err_flags - base_flags, 0);
    base_out = err_out; base_done = err_done; base_level = err_level; base_flags = err_flags;
  endtask

  // ---------------- single-frame vectors ----------------
  typedef struct {
    bit          use_b;
    logic [8:0]  data;
    logic [12:0] line;   // bit i = line level during the i-th bit period
    int          nbits;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    int   span, mism, ndone, done_c, first_low;
    logic line, exp;
    span = v.nbits * CPB;
    mism = 0; ndone = 0; done_c = -1; first_low = -1;
    if (v.use_b) begin wrEn_b = 1'b1; wrData_b = v.data; end
    else         begin wrEn_a = 1'b1; wrData_a = v.data[7:0]; end
    @(negedge clk);
    wrEn_a = 1'b0; wrEn_b = 1'b0;
    check($sformatf("v%0d_level_after_write", idx), v.use_b ? int'(level_b) : int'(level_a), 1);
    for (int c = 1; c <= span + 4; c++) begin
      @(negedge clk);
      line = v.use_b ? txOut_b : txOut_a;
      exp  = (c >= 2 && c < 2 + span) ? v.line[(c - 2) / CPB] : 1'b1;
      if (line !== exp) mism++;
      if (line === 1'b0 && first_low < 0) first_low = c;
      if ((v.use_b ? done_b : done_a) === 1'b1) begin ndone++; done_c = c; end
      if (c == 1) begin
        check($sformatf("v%0d_empty_after_pop", idx), v.use_b ? int'(empty_b) : int'(empty_a), 1);
        check($sformatf("v%0d_busy_after_pop", idx), v.use_b ? int'(busy_b) : int'(busy_a), 1);
      end
    end
    check($sformatf("v%0d_start_latency", idx), first_low, 2);
    check($sformatf("v%0d_line_bit_errs", idx), mism, 0);
    check($sformatf("v%0d_txDone_cycle", idx), done_c, span + 1);
    check($sformatf("v%0d_txDone_pulses", idx), ndone, 1);
  endtask

  initial begin
    int ndone, first_d, last_d, lows;
    int wp[6];

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{1'b0, 9'h0A5, 13'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vecs[1] = '{1'b0, 9'h007, 13'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
    vecs[2] = '{1'b0, 9'h001, 13'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vecs[3] = '{1'b0, 9'h0FE, 13'({1'b1, 1'b1, 8'hFE, 1'b0}), 11};
    vecs[4] = '{1'b0, 9'h03C, 13'({1'b1, 1'b0, 8'h3C, 1'b0}), 11};
    vecs[5] = '{1'b1, 9'h1FF, 13'({2'b11, 1'b0, 9'h1FF, 1'b0}), 13};
    vecs[6] = '{1'b1, 9'h007, 13'({2'b11, 1'b0, 9'h007, 1'b0}), 13};
`else
    vecs[0] = '{1'b0, 9'h0A5, 13'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{1'b0, 9'h007, 13'({1'b1, 8'h07, 1'b0}), 10};
    vecs[2] = '{1'b0, 9'h001, 13'({1'b1, 8'h01, 1'b0}), 10};
    vecs[3] = '{1'b0, 9'h0FE, 13'({1'b1, 8'hFE, 1'b0}), 10};
    vecs[4] = '{1'b0, 9'h03C, 13'({1'b1, 8'h3C, 1'b0}), 10};
    vecs[5] = '{1'b1, 9'h1FF, 13'({2'b11, 9'h1FF, 1'b0}), 12};
    vecs[6] = '{1'b1, 9'h007, 13'({2'b11, 9'h007, 1'b0}), 12};
`endif
    wp = '{40, 3, 0, 70, 8, 0};

    // reset values
    repeat (3) @(negedge clk);
    check("rst_txOut", txOut_a, 1);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_level", level_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_txBusy", busy_a, 0);
    check("rst_txDone", done_a, 0);
    check("rst_b_txOut", txOut_b, 1);
    rstN = 1'b1;
    txEn_a = 1'b1; txEn_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    model_check("vectors");

    // burst of 20 writes with transmission held off: 16 kept, 4 dropped
    txEn_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wrEn_a = 1'b1;
      wrData_a = 8'($urandom);
      @(negedge clk);
    end
    wrEn_a = 1'b0;
    check("burst_level", level_a, 16);
    check("burst_full", full_a, 1);
    check("burst_ovf", ovf_a, 1);
    txEn_a = 1'b1;
    ndone = 0; first_d = -1; last_d = -1;
    for (int c = 1; c <= 16 * 120 + 20; c++) begin
      @(negedge clk);
      if (done_a) begin
        ndone++;
        if (first_d < 0) first_d = c;
        last_d = c;
      end
    end
    check("burst_done_count", ndone, 16);
    check("burst_first_done", first_d, 121);
    check("burst_last_done", last_d, 16 * 120 + 1);
    check("burst_empty_end", empty_a, 1);
    check("burst_busy_end", busy_a, 0);
    model_check("burst");

    // txEn dropped mid-frame with words still queued
    txEn_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wrEn_a = 1'b1;
      wrData_a = 8'($urandom);
      @(negedge clk);
    end
    wrEn_a = 1'b0;
    txEn_a = 1'b1;
    @(negedge clk);
    check("drop_level_after_pop", level_a, 3);
    repeat (48) @(negedge clk);
    txEn_a = 1'b0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    check("drop_frame_completes", ndone, 1);
    check("drop_level_held", level_a, 3);
    check("drop_idle_busy", busy_a, 0);
    check("drop_idle_line", txOut_a, 1);
    txEn_a = 1'b1;
    @(negedge clk);
    check("resume_level", level_a, 2);
    check("resume_busy", busy_a, 1);
    @(negedge clk);
    check("resume_start_bit", txOut_a, 0);
    repeat (3 * 120 + 10) @(negedge clk);
    model_check("txen_drop");

    // asynchronous reset during DATA of an all-zero frame
    txEn_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wrEn_a = 1'b1;
      wrData_a = 8'h00;
      @(negedge clk);
    end
    wrEn_a = 1'b0;
    check("prerst_ovf", ovf_a, 1);
    txEn_a = 1'b1;
    repeat (40) @(negedge clk);
    check("prerst_line_low", txOut_a, 0);
    #2 rstN = 1'b0;
    #1;
    check("midrst_txOut", txOut_a, 1);
    check("midrst_level", level_a, 0);
    check("midrst_ovf", ovf_a, 0);
    check("midrst_empty", empty_a, 1);
    check("midrst_full", full_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    ndone = 0; lows = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
      if (!txOut_a) lows++;
    end
    check("postrst_no_done", ndone, 0);
    check("postrst_line_idle", lows, 0);
    model_check("reset");

    // randomized traffic against the model
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < 500; c++) begin
        wrEn_a   = ($urandom_range(99) < wp[s]);
        wrData_a = 8'($urandom);
        if ($urandom_range(199) == 0) txEn_a = ~txEn_a;
        @(negedge clk);
      end
    end
    wrEn_a = 1'b0;
    txEn_a = 1'b1;
    repeat (17 * 120 + 50) @(negedge clk);
    check("random_drained", empty_a, 1);
    model_check("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the fixed 8-bit UART transmitter: a buffered serial transmitter with configurable data width, stop-bit count and FIFO depth, plus optional parity. Host logic pushes words into an internal FIFO at clock rate. The block drains the FIFO as back-to-back frames on `txOut` with no idle gap. It sits between a byte/word producer and the physical TX pin, in the same slot as the existing 8-bit transmitter.

## Interface
- `CLOCK_RATE`, 12000000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in baud; `CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE` (integer division, must be ≥ 2)
- `DATA_BITS`, 8, data bits per frame, legal range 5–9
- `STOP_BITS`, 1, stop bits per frame, 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥ 2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (used only with parity compiled in)

Ports:
- `clk`  in  1  system clock, rising edge
- `rstN`  in  1  asynchronous active-low reset
- `txEn`  in  1  permits starting new frames
- `wrEn`  in  1  push `wrData` into the FIFO this cycle
- `wrData`  in  DATA_BITS  word to transmit, LSB sent first
- `full`  out  1  FIFO holds FIFO_DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `level`  out  $clog2(FIFO_DEPTH)+1  current entry count
- `ovf`  out  1  sticky: a write was attempted while full
- `txBusy`  out  1  a frame is in progress (state ≠ IDLE)
- `txDone`  out  1  one-cycle pulse on the last clock of each frame's final stop bit
- `txOut`  out  1  serial line, registered, idle high

## Operation
- Reset values: `txOut`=1, `empty`=1, `full`=0, `level`=0, `ovf`=0, `txBusy`=0, `txDone`=0. The FIFO pointers are cleared and the FSM is in IDLE.
- FIFO write: when `wrEn` is high and the FIFO is not full, the word is stored. When `wrEn` is high and the FIFO is full, the word is dropped and `ovf` is set; it stays set until reset.
- Simultaneous write and pop:
  - When full, the write is accepted and `level` is unchanged.
  - When empty, only the write takes effect; the pop happens on a following cycle.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: when `txEn` is high and the FIFO is not empty, pop the head word into the shift register and go to START.
  - START: drive `txOut`=0 for CLKS_PER_BIT clocks.
  - DATA: send DATA_BITS bits, LSB first, each CLKS_PER_BIT clocks.
  - PARITY: one bit, the XOR of the data bits, inverted when PARITY_ODD=1.
  - STOP: drive `txOut`=1 for STOP_BITS×CLKS_PER_BIT clocks. On the last clock, pulse `txDone`. If `txEn` is high and the FIFO is not empty, pop in the same cycle and go to START; otherwise go to IDLE.
- Per-bit timing comes from a baud counter that runs 0..CLKS_PER_BIT−1, restarts at every state entry, and wraps on each bit boundary. A bit counter tracks DATA and STOP progress.
- Deasserting `txEn` mid-frame does not abort the frame. The current frame completes and no further pop occurs.
- `wrData` is sampled only on an accepted write; later changes do not affect queued words.

## Timing
- Write into an empty FIFO with the FSM in IDLE and `txEn` high:
  - cycle 0: write edge;
  - cycle 1: `empty` falls and the pop occurs;
  - cycle 2: `txOut` falls (start bit). Latency from write to start bit is 2 clocks.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT clocks, where P = 1 with parity compiled in, else 0.
- Back-to-back frames: the start bit of frame N+1 begins on the clock immediately after `txDone` of frame N.
- `level`, `full`, `empty` and `ovf` update on the clock edge following the write or pop.
- Reset asserted mid-frame forces `txOut`=1 and all outputs to their reset values immediately (asynchronously). Queued data is lost.
- Deassertion of `rstN` is synchronised externally.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and each frame carries one parity bit per `PARITY_ODD`.
- Not defined: PARITY is skipped (DATA → STOP) and `PARITY_ODD` is ignored. The frame is start + DATA_BITS + STOP_BITS.

## Test plan
- Single frame: CLOCK_RATE=12000000, BAUD_RATE=1000000, 8N1, write 0xA5 → start bit 2 clocks after the write, line sequence 0,1,0,1,0,0,1,0,1,1 at 12 clocks per bit, `txDone` pulse at clock 121 after the write.
- Burst: write 20 bytes (30, 24, 19, … 2) in 20 consecutive cycles with FIFO_DEPTH=16 → bytes 17–20 dropped, `ovf`=1, 16 contiguous frames with no idle bits between them, then `empty`=1 and `txBusy`=0.
- Parity: `UART_TX_PARITY_EN` defined, PARITY_ODD=0, write 0x07 → parity bit 1; PARITY_ODD=1 → parity bit 0; 11-bit frame.
- Width and stop bits: DATA_BITS=9, STOP_BITS=2, write 0x1FF → 9 ones, then 2 stop bits of 24 clocks total, frame = 12×12 clocks.
- `txEn` dropped mid-frame with 3 words queued → current frame completes, `level` stays 3; re-raising `txEn` resumes on the next clock.
- `rstN` pulsed low during DATA → `txOut`=1 in the same cycle, `level`=0, `ovf`=0, no `txDone`.
